muldiv_unit: RTL and testbench

- Multi-cycle RV32M execution unit. Sits downstream of the ALU control generator, beside the integer ALU.
- Accepts a 6-bit ALUControl code plus two 32-bit operands, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and returns a 32-bit result.
- Asserts stall so the core holds the PC and suppresses register writeback while the operation runs.

---
 rtl/muldiv_unit_pkg.sv | 60 ++++++
 rtl/muldiv_unit_signfix.sv | 29 ++
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared ALU control codes, muldiv FSM encodings and op-class helpers
package muldiv_unit_pkg;

    localparam int MD_WIDTH      = 32;
    localparam int MD_CTRL_WIDTH = 6;
    localparam int MD_ITER_COUNT = 32;

    typedef logic [MD_CTRL_WIDTH-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD    = 6'd0;
    localparam alu_ctrl_t ALU_SUB    = 6'd1;
    localparam alu_ctrl_t ALU_AND    = 6'd2;
    localparam alu_ctrl_t ALU_OR     = 6'd3;
    localparam alu_ctrl_t ALU_XOR    = 6'd4;
    localparam alu_ctrl_t ALU_SLT    = 6'd5;
    localparam alu_ctrl_t ALU_SLTU   = 6'd6;
    localparam alu_ctrl_t ALU_SLL    = 6'd7;
    localparam alu_ctrl_t ALU_SRL    = 6'd8;
    localparam alu_ctrl_t ALU_SRA    = 6'd9;
    localparam alu_ctrl_t ALU_MUL    = 6'd16;
    localparam alu_ctrl_t ALU_MULH   = 6'd17;
    localparam alu_ctrl_t ALU_MULHSU = 6'd18;
    localparam alu_ctrl_t ALU_MULHU  = 6'd19;
    localparam alu_ctrl_t ALU_DIV    = 6'd20;
    localparam alu_ctrl_t ALU_DIVU   = 6'd21;
    localparam alu_ctrl_t ALU_REM    = 6'd22;
    localparam alu_ctrl_t ALU_REMU   = 6'd23;

    typedef enum logic [1:0] {
        MD_STATE_IDLE  = 2'd0,
        MD_STATE_CALC  = 2'd1,
        MD_STATE_FIXUP = 2'd2,
        MD_STATE_DONE  = 2'd3
    } md_state_t;

    function automatic logic is_m_op(input alu_ctrl_t c);
        return (c >= ALU_MUL) && (c <= ALU_REMU);
    endfunction

    function automatic logic is_mul_op(input alu_ctrl_t c);
        return c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_ctrl_t c);
        return c inside {ALU_DIV, ALU_DIVU};
    endfunction

    function automatic logic is_rem_op(input alu_ctrl_t c);
        return c inside {ALU_REM, ALU_REMU};
    endfunction

    function automatic logic op_a_signed(input alu_ctrl_t c);
        return c inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic op_b_signed(input alu_ctrl_t c);
        return c inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// rtl/muldiv_unit_signfix.sv - operand magnitudes and result negate flags for the muldiv datapath
module muldiv_signfix
    import muldiv_unit_pkg::*;
(
    input  alu_ctrl_t   op,
    input  logic        a_msb,
    input  logic        b_msb,
    input  logic [31:0] a_raw,
    input  logic [31:0] b_raw,
    output logic [31:0] a_abs,
    output logic [31:0] b_abs,
    output logic        neg_main,
    output logic        neg_rem
);

    logic a_neg;
    logic b_neg;

    always_comb begin
        a_neg    = op_a_signed(op) & a_msb;
        b_neg    = op_b_signed(op) & b_msb;
        a_abs    = a_neg ? -a_raw : a_raw;
        b_abs    = b_neg ? -b_raw : b_raw;
        neg_main = a_neg ^ b_neg;
        // remainder follows the dividend's sign only
        neg_rem  = a_neg;
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with stall/done handshake
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply, division stays iterative.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CTRL_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CTRL_WIDTH-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [WIDTH-1:0]      result
);

    md_state_t   state;
    md_state_t   state_next;
    alu_ctrl_t   op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] mag;
    logic [63:0] acc;
    logic [5:0]  iter;
    logic        prep;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        neg_main;
    logic        neg_rem;

    logic        accept;
    logic        quick;
    logic [31:0] quick_val;
    logic [63:0] mul_next;
    logic [63:0] div_next;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_signed;
    logic [31:0] fix_val;

    muldiv_signfix u_signfix (
        .op       (op_q),
        .a_msb    (a_q[31]),
        .b_msb    (b_q[31]),
        .a_raw    (a_q),
        .b_raw    (b_q),
        .a_abs    (a_abs),
        .b_abs    (b_abs),
        .neg_main (neg_main),
        .neg_rem  (neg_rem)
    );

    assign accept = start & is_m_op(alu_ctrl) & ~flush
                  & ((state == MD_STATE_IDLE) | (state == MD_STATE_DONE));

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a;
    logic signed [32:0] fast_b;
    logic signed [63:0] fast_prod;
    assign fast_a    = {op_a_signed(alu_ctrl) & op_a[31], op_a};
    assign fast_b    = {op_b_signed(alu_ctrl) & op_b[31], op_b};
    assign fast_prod = 64'(fast_a) * 64'(fast_b);
`endif

    // Results that bypass the iterative path are resolved from the raw inputs at accept.
    always_comb begin
        quick     = 1'b0;
        quick_val = '0;
        if (is_div_op(alu_ctrl) || is_rem_op(alu_ctrl)) begin
            if (op_b == '0) begin
                quick     = 1'b1;
                quick_val = is_div_op(alu_ctrl) ? 32'hFFFF_FFFF : op_a;
            end else if ((alu_ctrl == ALU_DIV || alu_ctrl == ALU_REM) &&
                         op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
                quick     = 1'b1;
                quick_val = (alu_ctrl == ALU_DIV) ? 32'h8000_0000 : 32'h0;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (is_mul_op(alu_ctrl)) begin
            quick     = 1'b1;
            quick_val = (alu_ctrl == ALU_MUL) ? fast_prod[31:0] : fast_prod[63:32];
        end
`endif
    end

    // acc holds {partial product, multiplier} for MUL* and {remainder, quotient} for DIV*/REM*.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = {acc[63:32], acc[31]};
        div_ge    = div_shift >= {1'b0, mag};
        div_diff  = div_shift[31:0] - mag;
        div_next  = {div_ge ? div_diff : div_shift[31:0], acc[30:0], div_ge};
    end

    always_comb begin
        prod_signed = neg_main ? -acc : acc;
        fix_val     = '0;
        if (op_q == ALU_MUL)
            fix_val = prod_signed[31:0];
        else if (is_mul_op(op_q))
            fix_val = prod_signed[63:32];
        else if (is_div_op(op_q))
            fix_val = neg_main ? -acc[31:0] : acc[31:0];
        else
            fix_val = neg_rem ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MD_STATE_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = MD_STATE_IDLE;
        end else begin
            case (state)
                MD_STATE_IDLE:
                    if (accept) state_next = quick ? MD_STATE_DONE : MD_STATE_CALC;
                MD_STATE_CALC:
                    if (!prep && iter == 6'(MD_ITER_COUNT - 1)) state_next = MD_STATE_FIXUP;
                MD_STATE_FIXUP:
                    state_next = MD_STATE_DONE;
                MD_STATE_DONE:
                    if (accept) state_next = quick ? MD_STATE_DONE : MD_STATE_CALC;
                    else        state_next = MD_STATE_IDLE;
                default:
                    state_next = MD_STATE_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            MD_STATE_CALC, MD_STATE_FIXUP: busy = 1'b1;
            MD_STATE_DONE:                 done = 1'b1;
            default: ;
        endcase
        stall = busy | accept;
    end

    // First CALC cycle (prep) loads magnitudes from the registered operands before iterating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mag    <= '0;
            acc    <= '0;
            iter   <= '0;
            prep   <= 1'b0;
            result <= '0;
        end else if (!flush) begin
            if (accept) begin
                op_q <= alu_ctrl;
                a_q  <= op_a;
                b_q  <= op_b;
                iter <= '0;
                prep <= 1'b1;
                if (quick) result <= quick_val;
            end else if (state == MD_STATE_CALC) begin
                if (prep) begin
                    prep <= 1'b0;
                    if (is_mul_op(op_q)) begin
                        mag <= a_abs;
                        acc <= {32'h0, b_abs};
                    end else begin
                        mag <= b_abs;
                        acc <= {32'h0, a_abs};
                    end
                end else begin
                    acc  <= is_mul_op(op_q) ? mul_next : div_next;
                    iter <= iter + 6'd1;
                end
            end else if (state == MD_STATE_FIXUP) begin
                result <= fix_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 35;
`endif
    localparam int LONG_LAT = 35;
    localparam int NVEC     = 15;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [5:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        int          lat;
    } vec_t;

    vec_t vecs[NVEC];

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act === want) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    endtask

    // Called just after a negedge; returns at the negedge where done was seen.
    task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output logic st);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        #1 st = stall;
        @(posedge clk);
        #1 start = 1'b0;
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = result;
    endtask

    logic [31:0] res;
    logic [31:0] prev;
    int          lat;
    int          bcnt;
    int          done_cnt;
    logic        st;

    initial begin
        vecs[0]  = '{ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LONG_LAT};
        vecs[1]  = '{ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LONG_LAT};
        vecs[2]  = '{ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
        vecs[3]  = '{ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[4]  = '{ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT};
        vecs[5]  = '{ALU_DIVU,   32'h0000_1234, 32'h0,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{ALU_REMU,   32'h0000_1234, 32'h0,         32'h0000_1234, 1};
        vecs[7]  = '{ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[8]  = '{ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[9]  = '{ALU_DIVU,   32'd100,       32'd7,         32'd14,        LONG_LAT};
        vecs[10] = '{ALU_REMU,   32'd100,       32'd7,         32'd2,         LONG_LAT};
        vecs[11] = '{ALU_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[12] = '{ALU_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         LONG_LAT};
        vecs[13] = '{ALU_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LONG_LAT};
        vecs[14] = '{ALU_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, MUL_LAT};

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        alu_ctrl = ALU_ADD;
        op_a     = '0;
        op_b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   {31'b0, busy},  32'd0);
        check("reset done",   {31'b0, done},  32'd0);
        check("reset stall",  {31'b0, stall}, 32'd0);
        check("reset result", result,         32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, res, lat, bcnt, st);
            check($sformatf("vec%0d result", i),  res,          vecs[i].want);
            check($sformatf("vec%0d latency", i), lat,          vecs[i].lat);
            check($sformatf("vec%0d busy", i),    bcnt,         (vecs[i].lat == LONG_LAT) ? 34 : 0);
            check($sformatf("vec%0d stall", i),   {31'b0, st},  32'd1);
            @(negedge clk);
        end

        // flush at cycle 10 of DIVU 100/7: no done, result unchanged, then a clean rerun
        prev     = result;
        alu_ctrl = ALU_DIVU;
        op_a     = 32'd100;
        op_b     = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", {31'b0, busy}, 32'd0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("flush no done", done_cnt, 0);
        check("flush result held", result, prev);
        run_op(ALU_DIVU, 32'd100, 32'd7, res, lat, bcnt, st);
        check("after flush result", res, 32'd14);
        @(negedge clk);

        // async reset at cycle 20 of an operation
        alu_ctrl = ALU_DIV;
        op_a     = 32'hFFFF_FFF9;
        op_b     = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midop rst busy",   {31'b0, busy},  32'd0);
        check("midop rst done",   {31'b0, done},  32'd0);
        check("midop rst stall",  {31'b0, stall}, 32'd0);
        check("midop rst result", result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // non-M code is ignored
        alu_ctrl = ALU_ADD;
        op_a     = 32'd5;
        op_b     = 32'd6;
        start    = 1'b1;
        #1 check("add stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        bcnt     = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) bcnt++;
        end
        check("add busy", bcnt, 0);
        check("add no done", done_cnt, 0);

        // start while busy is ignored
        alu_ctrl = ALU_DIV;
        op_a     = 32'hFFFF_FFF9;
        op_b     = 32'd2;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 5) begin
                alu_ctrl = ALU_MULHU;
                op_a     = 32'hFFFF_FFFF;
                op_b     = 32'hFFFF_FFFF;
                start    = 1'b1;
                #1 check("busy start stall", {31'b0, stall}, 32'd1);
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("busy start latency", lat, LONG_LAT);
        check("busy start result", result, 32'hFFFF_FFFD);

        // new start accepted in the DONE cycle
        run_op(ALU_REMU, 32'd100, 32'd7, res, lat, bcnt, st);
        check("b2b result", res, 32'd2);
        check("b2b latency", lat, LONG_LAT);
        check("b2b stall", {31'b0, st}, 32'd1);

        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("idle no done", done_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
